// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding, requester
// index assignments and the value the shared bus rests at when nobody owns it.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StGuardIn  = 2'd1,
    StGranted  = 2'd2,
    StGuardOut = 2'd3
  } arb_state_e;

  // Requester slots on this board.
  localparam int unsigned REQ_FLASH = 0;
  localparam int unsigned REQ_DAC   = 1;
  localparam int unsigned REQ_AMP   = 2;

  // Idle bus: clock low, data low, every chip select deasserted.
  localparam logic IDLE_SCK  = 1'b0;
  localparam logic IDLE_MOSI = 1'b0;
  localparam logic IDLE_CS_N = 1'b1;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the per-master request/SPI signals and the shared SPI pins.
//   slave  : arbiter view (takes master requests and MISO pin, drives grant and pins)
//   master : environment view (the SPI masters plus the board pins)
interface spi_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_sck;
  logic [NUM_REQ-1:0] req_mosi;
  logic [NUM_REQ-1:0] req_cs_n;
  logic [NUM_REQ-1:0] grant;
  logic               req_miso;
  logic               bus_sck;
  logic               bus_mosi;
  logic [NUM_REQ-1:0] bus_cs_n;
  logic               bus_miso;

  modport slave (
    input  req, req_sck, req_mosi, req_cs_n, bus_miso,
    output grant, req_miso, bus_sck, bus_mosi, bus_cs_n
  );

  modport master (
    output req, req_sck, req_mosi, req_cs_n, bus_miso,
    input  grant, req_miso, bus_sck, bus_mosi, bus_cs_n
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of eligible scanning upward
// from rr_ptr, wrapping modulo NUM_REQ.
//   eligible : candidate requesters
//   rr_ptr   : highest-priority index this round (must be < NUM_REQ)
//   idx      : chosen requester (0 when valid is low)
//   valid    : at least one eligible requester
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  always_comb begin
    int unsigned      j;
    logic [IdxW-1:0]  cand;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // rr_ptr < NUM_REQ, so one subtraction is enough to wrap.
      j = 32'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IdxW'(j);
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus between NUM_REQ masters.
// Grants one owner at a time with idle guard time on both sides of each
// tenure and force-releases owners that exceed TIMEOUT_CYCLES. All pin
// outputs are registered so an owner change cannot glitch SCK or a CS.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : requests, per-master SPI, grant and shared pins (slave side)
//   busy         : FSM is not in IDLE
//   timeout_err  : sticky, set on a forced release
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_bus_arbiter_if.slave bus,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned     IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]      GuardLoad = 4'(GUARD_CYCLES);
  localparam bit              TmoEn     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TenureMax = TmoEn ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]         guard_q, guard_d;
  logic [CNT_W-1:0]   tenure_q, tenure_d;
  logic [NUM_REQ-1:0] blocked_q, blocked_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic               tmo_err_q, tmo_err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  assign eligible = bus.req & ~blocked_q;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    guard_d   = guard_q;
    tenure_d  = tenure_q;
    grant_d   = grant_q;
    tmo_err_d = tmo_err_q;
    // Pins rest idle unless the owner is actively passed through below.
    sck_d     = IDLE_SCK;
    mosi_d    = IDLE_MOSI;
    cs_n_d    = {NUM_REQ{IDLE_CS_N}};
    // A block lifts as soon as its master lets go of req.
    blocked_d = blocked_q & bus.req;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          guard_d = GuardLoad;
          state_d = StGuardIn;
        end
      end
      StGuardIn: begin
        if (!bus.req[owner_q]) begin
          guard_d = GuardLoad;
          state_d = StGuardOut;
        end else if (guard_q == 4'd1) begin
          grant_d          = '0;
          grant_d[owner_q] = 1'b1;
          tenure_d         = '0;
          state_d          = StGranted;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      StGranted: begin
        // A voluntary drop wins over a timeout landing on the same edge.
        if (!bus.req[owner_q] || (TmoEn && tenure_q == TenureMax)) begin
          grant_d = '0;
          guard_d = GuardLoad;
          state_d = StGuardOut;
          if (bus.req[owner_q]) begin
            tmo_err_d          = 1'b1;
            blocked_d[owner_q] = 1'b1;
          end
        end else begin
          sck_d           = bus.req_sck[owner_q];
          mosi_d          = bus.req_mosi[owner_q];
          cs_n_d[owner_q] = bus.req_cs_n[owner_q];
          tenure_d        = tenure_q + CNT_W'(1);
        end
      end
      StGuardOut: begin
        if (guard_q == 4'd1) begin
          rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);
          state_d  = StIdle;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      owner_q   <= IdxW'(REQ_FLASH);
      rr_ptr_q  <= IdxW'(REQ_FLASH);
      guard_q   <= '0;
      tenure_q  <= '0;
      blocked_q <= '0;
      grant_q   <= '0;
      sck_q     <= IDLE_SCK;
      mosi_q    <= IDLE_MOSI;
      cs_n_q    <= {NUM_REQ{IDLE_CS_N}};
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      guard_q   <= guard_d;
      tenure_q  <= tenure_d;
      blocked_q <= blocked_d;
      grant_q   <= grant_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.bus_sck  = sck_q;
  assign bus.bus_mosi = mosi_q;
  assign bus.bus_cs_n = cs_n_q;
  assign bus.req_miso = bus.bus_miso;
  assign busy         = (state_q != StIdle);
  assign timeout_err  = tmo_err_q;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the board's single SPI bus (SCK/MOSI/MISO) between up to NUM_REQ masters: SPI flash RDID master, DAC, pre-amp.
- Sits between those masters and the top-level SPI pins.
- Grants one owner at a time, round-robin.
- Holds every non-owner chip select deasserted, inserts guard time around each tenure, and force-releases owners that hold the bus too long.
- All bus outputs are registered, so switching owners cannot glitch SCK or a chip select.

Parameters:
NUM_REQ, 3, number of requesters; index 0 flash, 1 DAC, 2 pre-amp
GUARD_CYCLES, 2, idle-bus cycles before each grant and after each release (1..15)
TIMEOUT_CYCLES, 4096, max cycles a grant may be held; 0 disables timeout
CNT_W, 13, width of the tenure counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock (divided DCM clock)
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  bus request per master, level; held high for the whole transfer
req_sck  in  NUM_REQ  per-master SCK
req_mosi  in  NUM_REQ  per-master MOSI
req_cs_n  in  NUM_REQ  per-master chip select, active-low
grant  out  NUM_REQ  one-hot grant, registered
bus_sck  out  1  to SPISCK pin
bus_mosi  out  1  to SPIMOSI pin
bus_cs_n  out  NUM_REQ  per-device chip select pins, active-low
bus_miso  in  1  from SPIMISO pin
req_miso  out  1  bus_miso passed through combinationally to all masters
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set when a forced release occurs

Behaviour:
- Reset (async, reset_n low) values:
  - state=IDLE; grant=0; bus_cs_n all 1; bus_sck=0; bus_mosi=0.
  - rr_ptr=0; owner=0; busy=0; timeout_err=0; blocked mask=0.
- Idle bus value: bus_sck=0, bus_mosi=0, bus_cs_n all 1.
- IDLE:
  - eligible = req & ~blocked.
  - If eligible is nonzero, pick the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the pick as owner, load guard counter with GUARD_CYCLES, go to GUARD_IN.
  - Bus stays idle.
- GUARD_IN:
  - Bus idle; counter decrements each cycle.
  - When the counter hits 0: grant[owner]<=1, tenure counter<=0, go to GRANTED.
  - If req[owner] falls during GUARD_IN: no grant is issued; go to GUARD_OUT.
- GRANTED:
  - Each edge registers bus_sck<=req_sck[owner], bus_mosi<=req_mosi[owner], bus_cs_n[owner]<=req_cs_n[owner]; every other bus_cs_n<=1.
  - Pin latency from master signals is exactly 1 clk. Masters must start driving only after sampling grant high.
  - Tenure counter increments each cycle.
  - req[owner] low: grant<=0, bus idle from the same edge, go to GUARD_OUT.
  - Timeout (TIMEOUT_CYCLES≠0 and tenure counter reaches TIMEOUT_CYCLES-1): forced release exactly like a normal release, plus timeout_err<=1 and blocked[owner]<=1.
  - If req[owner] falls on the same edge the timeout fires, it is a normal release: no error, no block.
- GUARD_OUT:
  - Bus idle; counts GUARD_CYCLES.
  - Then rr_ptr<=(owner+1) mod NUM_REQ and go to IDLE.
- Latency, with GUARD_CYCLES=G:
  - req sampled high at edge k gives grant high after edge k+1+G.
  - Minimum gap from one grant falling to the next grant rising is 2G+1 cycles.
- Blocked mask: blocked[i] clears on any edge where req[i]=0. A timed-out master must drop req before it is eligible again.
- Requests from non-owners while the bus is busy are ignored until IDLE. No preemption.
- Round-robin fairness: with all requesters continuously requesting, the grant order is 0,1,2,0,…
- timeout_err clears only on reset.
- At most one bit of grant and at most one bit of bus_cs_n is ever active.
- Reset mid-transfer: all outputs go to reset values immediately, with no clock required.

Decomposition:
- Shared package spi_arb_pkg holds:
  - state encoding: IDLE, GUARD_IN, GRANTED, GUARD_OUT (2 bits);
  - requester index constants REQ_FLASH=0, REQ_DAC=1, REQ_AMP=2;
  - the idle-bus constant values.
- One natural sub-module: rr_priority_pick, purely combinational.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: index and valid.
- FSM, counters and registered output mux stay in spi_bus_arbiter.

Test Plan:
- Reset: hold reset_n=0 mid-GRANTED -> grant=000, bus_cs_n=111, bus_sck=0 immediately; after release the FSM is in IDLE, busy=0.
- Single request, G=2: req=001 at edge 0 -> grant=001 after edge 3; req_cs_n[0]=0 at edge 5 shows bus_cs_n=110 after edge 6; req drop -> grant=000 next edge, bus_cs_n=111.
- Simultaneous req=111 held, each master releases after 8 cycles -> grant sequence 001,010,100,001; no two grants within 5 cycles; bus_cs_n never has two zeros.
- Pass-through: owner toggles req_sck every cycle with MOSI pattern A5h -> pins reproduce the pattern delayed 1 clk; non-owner SCK/MOSI activity never reaches the pins.
- Timeout, TIMEOUT_CYCLES=16: master 1 holds req -> grant drops after 16 granted cycles, timeout_err=1; master 1 is not regranted until req falls and rises again; master 2 requesting meanwhile gets the bus.
- Abort in guard: req=100 then drop during GUARD_IN -> grant stays 000, passes through GUARD_OUT, rr_ptr advances to 0.
